rank_filter_3x3: RTL and testbench

- Streaming 3x3 rank filter: generalised successor of the fixed median filter.
- Parameters: pixel width, packed channel count, image size.
- Run-time mode selects bypass, median, min or max per frame.
- Sits between the pixel source and downstream image stages.
- Replaces the median_filter core used under the top-level wrapper; start_i/done_o frame control is retained.

---
 rtl/rank_filter_pkg.sv | 20 ++
 rtl/rank_filter_3x3_rank9_sort.sv | 133 +++++++++++++
 rtl/rank_filter_3x3.sv | 157 +++++++++++++++
 tb/tb_rank_filter_3x3.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_filter_pkg.sv
// Shared types and constants for the streaming 3x3 rank filter.
package rank_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_MEDIAN = 2'd1,
        MODE_MIN    = 2'd2,
        MODE_MAX    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    localparam int SORT_LAT = 4;

endpackage

// File: rtl/rank_filter_3x3_rank9_sort.sv
// Per-channel 4-stage compare-exchange network selecting median/min/max of a
// 3x3 window, or passing the centre sample through for bypass and borders.
module rank9_sort
    import rank_filter_pkg::*;
#(
    parameter int PIXEL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9*PIXEL_W-1:0] win,
    input  logic                 border,
    input  mode_t                mode,
    input  logic                 valid,
    output logic [PIXEL_W-1:0]   result,
    output logic                 result_valid
);

    typedef logic [PIXEL_W-1:0] pix_t;

    // Returns {hi, mid, lo}.
    function automatic logic [3*PIXEL_W-1:0] sort3(input pix_t a, input pix_t b, input pix_t c);
        pix_t lo;
        pix_t hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)
            return {hi, lo, c};
        else if (c > hi)
            return {c, hi, lo};
        return {hi, c, lo};
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        logic [3*PIXEL_W-1:0] s;
        s = sort3(a, b, c);
        return s[0 +: PIXEL_W];
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        logic [3*PIXEL_W-1:0] s;
        s = sort3(a, b, c);
        return s[PIXEL_W +: PIXEL_W];
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        logic [3*PIXEL_W-1:0] s;
        s = sort3(a, b, c);
        return s[2*PIXEL_W +: PIXEL_W];
    endfunction

    pix_t smp [9];
    pix_t row_lo [3];
    pix_t row_mid [3];
    pix_t row_hi [3];

    always_comb begin
        for (int i = 0; i < 9; i++)
            smp[i] = win[i*PIXEL_W +: PIXEL_W];
        for (int r = 0; r < 3; r++) begin
            row_lo[r]  = min3(smp[3*r], smp[3*r+1], smp[3*r+2]);
            row_mid[r] = med3(smp[3*r], smp[3*r+1], smp[3*r+2]);
            row_hi[r]  = max3(smp[3*r], smp[3*r+1], smp[3*r+2]);
        end
    end

    pix_t  lo_p0 [3], mid_p0 [3], hi_p0 [3], ctr_p0;
    logic  border_p0, vld_p0;
    mode_t mode_p0;
    pix_t  lomax_p1, midmed_p1, himin_p1, min_p1, max_p1, ctr_p1;
    logic  border_p1, vld_p1;
    mode_t mode_p1;
    pix_t  med_p2, min_p2, max_p2, ctr_p2;
    logic  border_p2, vld_p2;
    mode_t mode_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                lo_p0[r]  <= '0;
                mid_p0[r] <= '0;
                hi_p0[r]  <= '0;
            end
            {ctr_p0, border_p0, vld_p0} <= '0;
            mode_p0 <= MODE_BYPASS;
            {lomax_p1, midmed_p1, himin_p1, min_p1, max_p1, ctr_p1, border_p1, vld_p1} <= '0;
            mode_p1 <= MODE_BYPASS;
            {med_p2, min_p2, max_p2, ctr_p2, border_p2, vld_p2} <= '0;
            mode_p2 <= MODE_BYPASS;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            // p0: each window row sorted
            lo_p0     <= row_lo;
            mid_p0    <= row_mid;
            hi_p0     <= row_hi;
            ctr_p0    <= smp[4];
            border_p0 <= border;
            mode_p0   <= mode;
            vld_p0    <= valid;
            // p1: column reductions; the global extremes come free from the row sort
            lomax_p1  <= max3(lo_p0[0], lo_p0[1], lo_p0[2]);
            midmed_p1 <= med3(mid_p0[0], mid_p0[1], mid_p0[2]);
            himin_p1  <= min3(hi_p0[0], hi_p0[1], hi_p0[2]);
            min_p1    <= min3(lo_p0[0], lo_p0[1], lo_p0[2]);
            max_p1    <= max3(hi_p0[0], hi_p0[1], hi_p0[2]);
            ctr_p1    <= ctr_p0;
            border_p1 <= border_p0;
            mode_p1   <= mode_p0;
            vld_p1    <= vld_p0;
            // p2: median of the three column candidates is the 9-sample median
            med_p2    <= med3(lomax_p1, midmed_p1, himin_p1);
            min_p2    <= min_p1;
            max_p2    <= max_p1;
            ctr_p2    <= ctr_p1;
            border_p2 <= border_p1;
            mode_p2   <= mode_p1;
            vld_p2    <= vld_p1;
            // p3: rank select
            result_valid <= vld_p2;
            if (border_p2 || mode_p2 == MODE_BYPASS)
                result <= ctr_p2;
            else begin
                case (mode_p2)
                    MODE_MEDIAN: result <= med_p2;
                    MODE_MIN:    result <= min_p2;
                    MODE_MAX:    result <= max_p2;
                    default:     result <= ctr_p2;
                endcase
            end
        end
    end

endmodule

// File: rtl/rank_filter_3x3.sv
// Streaming 3x3 rank filter: frame FSM, raster counters, two line buffers,
// window register and one rank9_sort per packed channel.
module rank_filter_3x3
    import rank_filter_pkg::*;
#(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int PIXEL_W      = 8,
    parameter int CHANNELS     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [1:0]                    mode_i,
    input  logic                          valid_i,
    input  logic [CHANNELS*PIXEL_W-1:0]   pixel_i,
    output logic                          valid_o,
    output logic [CHANNELS*PIXEL_W-1:0]   pixel_o,
    output logic                          done_o
);

    localparam int PIX_W = CHANNELS * PIXEL_W;
    localparam int N     = IMAGE_LEN * IMAGE_HEIGHT;
    localparam int COL_W = $clog2(IMAGE_LEN);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int CNT_W = $clog2(N);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t            state, state_nxt;
    mode_t             mode_q;
    logic [COL_W-1:0]  col, ocol;
    logic [ROW_W-1:0]  row, orow;
    logic [CNT_W-1:0]  out_count;
    logic [SORT_LAT-1:0] last_pipe;
    logic [CHANNELS-1:0] ch_valid;

    logic start_ok, accept, advance, primed, emit, last_in, flush_end, last_emit, border;

    assign start_ok  = (state == IDLE) && start_i;
    assign accept    = (state == RUN) && valid_i;
    assign advance   = accept || (state == FLUSH);
    // First output needs input IMAGE_LEN+1, i.e. raster position (1,1).
    assign primed    = (row != '0) && !(row == ROW_W'(1) && col == '0);
    assign emit      = advance && ((state == FLUSH) || primed);
    assign last_in   = accept && (row == ROW_LAST) && (col == COL_LAST);
    // Counters wrap to (0,0) after the last input, so injection IMAGE_LEN+1 lands on (1,0).
    assign flush_end = (state == FLUSH) && (row == ROW_W'(1)) && (col == '0);
    assign last_emit = emit && (out_count == CNT_LAST);
    assign border    = (orow == '0) || (orow == ROW_LAST) || (ocol == '0) || (ocol == COL_LAST);
    assign done_o    = last_pipe[SORT_LAT-1];
    assign valid_o   = &ch_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)   state_nxt = RUN;
            RUN:     if (last_in)   state_nxt = FLUSH;
            FLUSH:   if (flush_end) state_nxt = DRAIN;
            DRAIN:   if (done_o)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {col, row, ocol, orow, out_count} <= '0;
            mode_q <= MODE_BYPASS;
        end else if (start_ok) begin
            {col, row, ocol, orow, out_count} <= '0;
            mode_q <= mode_t'(mode_i);
        end else begin
            if (advance) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else
                    col <= col + COL_W'(1);
            end
            if (emit) begin
                if (ocol == COL_LAST) begin
                    ocol <= '0;
                    orow <= (orow == ROW_LAST) ? '0 : orow + ROW_W'(1);
                end else
                    ocol <= ocol + COL_W'(1);
                if (out_count != CNT_LAST)
                    out_count <= out_count + CNT_W'(1);
            end
        end
    end

    logic [PIX_W-1:0] lb_top [IMAGE_LEN];
    logic [PIX_W-1:0] lb_mid [IMAGE_LEN];
    logic [PIX_W-1:0] top_new, mid_new;
    logic [PIX_W-1:0] win_top [2], win_mid [2], win_bot [2];

    assign top_new = lb_top[col];
    assign mid_new = lb_mid[col];

    always_ff @(posedge clk) begin
        if (advance) begin
            lb_top[col] <= mid_new;
            lb_mid[col] <= pixel_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                win_top[i] <= '0;
                win_mid[i] <= '0;
                win_bot[i] <= '0;
            end
            last_pipe <= '0;
        end else begin
            if (advance) begin
                win_top[0] <= win_top[1];
                win_top[1] <= top_new;
                win_mid[0] <= win_mid[1];
                win_mid[1] <= mid_new;
                win_bot[0] <= win_bot[1];
                win_bot[1] <= pixel_i;
            end
            last_pipe <= {last_pipe[SORT_LAT-2:0], last_emit};
        end
    end

    // The new column enters the sorter directly; sample 4 is the centre.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [9*PIXEL_W-1:0] win9;
        assign win9 = {pixel_i[ch*PIXEL_W +: PIXEL_W],    win_bot[1][ch*PIXEL_W +: PIXEL_W],
                       win_bot[0][ch*PIXEL_W +: PIXEL_W], mid_new[ch*PIXEL_W +: PIXEL_W],
                       win_mid[1][ch*PIXEL_W +: PIXEL_W], win_mid[0][ch*PIXEL_W +: PIXEL_W],
                       top_new[ch*PIXEL_W +: PIXEL_W],    win_top[1][ch*PIXEL_W +: PIXEL_W],
                       win_top[0][ch*PIXEL_W +: PIXEL_W]};

        rank9_sort #(.PIXEL_W(PIXEL_W)) u_sort (
            .clk          (clk),
            .rst_n        (rst_n),
            .win          (win9),
            .border       (border),
            .mode         (mode_q),
            .valid        (emit),
            .result       (pixel_o[ch*PIXEL_W +: PIXEL_W]),
            .result_valid (ch_valid[ch])
        );
    end

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Self-checking bench for rank_filter_3x3: a 1-channel and a 3-channel instance
// share control and are compared against a direct 3x3 rank model.
module tb_rank_filter_3x3;
    import rank_filter_pkg::*;

    localparam int L  = 4;
    localparam int H  = 3;
    localparam int N  = L * H;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic [3*PW-1:0] pin3 = '0;
    logic [PW-1:0] pin1;
    logic [PW-1:0] pout1;
    logic [3*PW-1:0] pout3;
    logic          v1, v3, dn1, dn3;

    assign pin1 = pin3[PW-1:0];

    rank_filter_3x3 #(.IMAGE_LEN(L), .IMAGE_HEIGHT(H), .PIXEL_W(PW), .CHANNELS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .valid_i(valid_i),
        .pixel_i(pin1), .valid_o(v1), .pixel_o(pout1), .done_o(dn1));

    rank_filter_3x3 #(.IMAGE_LEN(L), .IMAGE_HEIGHT(H), .PIXEL_W(PW), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .valid_i(valid_i),
        .pixel_i(pin3), .valid_o(v3), .pixel_o(pout3), .done_o(dn3));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int img [3][N];
    int acc [N];
    int q1v[$], q1c[$], q3v[$], q3c[$];
    int d1_cnt, d1_idx, d1_bad, d3_cnt, d3_idx, d3_bad;
    int n_checks = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (v1) begin q1v.push_back(int'(pout1)); q1c.push_back(cyc); end
        if (v3) begin q3v.push_back(int'(pout3)); q3c.push_back(cyc); end
        if (dn1) begin d1_cnt++; d1_idx = q1v.size() - 1; if (!v1) d1_bad++; end
        if (dn3) begin d3_cnt++; d3_idx = q3v.size() - 1; if (!v3) d3_bad++; end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int ch, input int k, input int mode);
        int r, c, t;
        int s [9];
        r = k / L;
        c = k % L;
        if (mode == 0 || r == 0 || r == H - 1 || c == 0 || c == L - 1)
            return img[ch][k];
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s[dr*3+dc] = img[ch][(r+dr-1)*L + (c+dc-1)];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        case (mode)
            1: return s[4];
            2: return s[0];
            default: return s[8];
        endcase
    endfunction

    function automatic int exp_pixel(input int k, input int mode);
        return (model(2, k, mode) << 16) | (model(1, k, mode) << 8) | model(0, k, mode);
    endfunction

    task automatic clear_mon();
        q1v.delete(); q1c.delete(); q3v.delete(); q3c.delete();
        d1_cnt = 0; d1_idx = -1; d1_bad = 0;
        d3_cnt = 0; d3_idx = -1; d3_bad = 0;
    endtask

    // gap: 0 none, 1 alternate cycles, 2 random bubbles
    task automatic run_frame(input string name, input int mode, input int gap, input bit pulse);
        int i, n, w, ecyc;
        bit ph;
        clear_mon();
        @(posedge clk); #1;
        start_i = 1'b1;
        mode_i  = 2'(mode);
        @(posedge clk); #1;
        start_i = 1'b0;
        i = 0; n = 0; ph = 1'b0;
        while (i < N) begin
            start_i = pulse && (n == 3 || n == 9);
            mode_i  = pulse ? 2'($urandom_range(0, 3)) : 2'(mode);
            if ((gap == 1 && ph) || (gap == 2 && $urandom_range(0, 2) == 0))
                valid_i = 1'b0;
            else begin
                valid_i = 1'b1;
                pin3 = {8'(img[2][i]), 8'(img[1][i]), 8'(img[0][i])};
                acc[i] = cyc;
                i++;
            end
            ph = !ph;
            n++;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        start_i = 1'b0;
        w = 0;
        while ((d1_cnt == 0 || d3_cnt == 0) && w < 200) begin
            @(posedge clk);
            w++;
        end
        check_eq({name, " done_seen"}, int'(d1_cnt > 0 && d3_cnt > 0), 1);
        repeat (6) @(posedge clk);
        #1;
        check_eq({name, " count1"}, q1v.size(), N);
        check_eq({name, " count3"}, q3v.size(), N);
        check_eq({name, " done_cnt1"}, d1_cnt, 1);
        check_eq({name, " done_cnt3"}, d3_cnt, 1);
        check_eq({name, " done_idx1"}, d1_idx, N - 1);
        check_eq({name, " done_idx3"}, d3_idx, N - 1);
        check_eq({name, " done_novalid"}, d1_bad + d3_bad, 0);
        for (int k = 0; k < N; k++) begin
            ecyc = (k < N - L - 1) ? acc[k+L+1] + SORT_LAT : acc[N-1] + (k - (N - L - 1)) + 1 + SORT_LAT;
            if (k < q1v.size()) begin
                check_eq($sformatf("%s val1[%0d]", name, k), q1v[k], model(0, k, mode));
                check_eq($sformatf("%s cyc1[%0d]", name, k), q1c[k], ecyc);
            end
            if (k < q3v.size()) begin
                check_eq($sformatf("%s val3[%0d]", name, k), q3v[k], exp_pixel(k, mode));
                check_eq($sformatf("%s cyc3[%0d]", name, k), q3c[k], ecyc);
            end
        end
    endtask

    task automatic fill_impulse();
        for (int k = 0; k < N; k++) begin
            img[0][k] = (k == 1*L + 1) ? 200 : 10;
            img[1][k] = 50;
            img[2][k] = k;
        end
    endtask

    task automatic fill_random(input int maxv);
        for (int k = 0; k < N; k++)
            for (int ch = 0; ch < 3; ch++)
                img[ch][k] = $urandom_range(0, maxv);
    endtask

    task automatic abort_feed(input int count);
        @(posedge clk); #1;
        start_i = 1'b1;
        mode_i  = 2'd0;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < count; i++) begin
            valid_i = 1'b1;
            pin3 = {8'(i), 8'(i), 8'(i)};
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset valid1", int'(v1), 0);
        check_eq("reset valid3", int'(v3), 0);
        check_eq("reset pixel1", int'(pout1), 0);
        check_eq("reset pixel3", int'(pout3), 0);
        check_eq("reset done", int'(dn1) + int'(dn3), 0);
        rst_n = 1'b1;

        for (int k = 0; k < N; k++) begin
            img[0][k] = k;
            img[1][k] = $urandom_range(0, 255);
            img[2][k] = $urandom_range(0, 255);
        end
        run_frame("bypass_ramp", 0, 0, 1'b0);

        fill_impulse();
        run_frame("median_impulse", 1, 0, 1'b0);
        run_frame("max_impulse", 3, 0, 1'b0);
        run_frame("median_gaps_pulses", 1, 1, 1'b1);

        // Abort after 5 inputs, before any output exists.
        abort_feed(5);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort5 valid", int'(v1) + int'(v3), 0);
        check_eq("abort5 done", int'(dn1) + int'(dn3), 0);
        release_reset();

        // Abort while output 1 is on the bus: must clear without a clock edge.
        abort_feed(10);
        check_eq("abort10 pre valid", int'(v1 && v3), 1);
        check_eq("abort10 pre pixel3", int'(pout3), 32'h010101);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort10 valid", int'(v1) + int'(v3), 0);
        check_eq("abort10 pixel", int'(pout1) + int'(pout3), 0);
        check_eq("abort10 done", int'(dn1) + int'(dn3), 0);
        release_reset();

        for (int k = 0; k < N; k++) begin
            img[0][k] = k;
            img[1][k] = k;
            img[2][k] = k;
        end
        run_frame("restart_ramp", 0, 0, 1'b0);

        for (int m = 1; m <= 3; m++) begin
            fill_random(255);
            run_frame($sformatf("rand_m%0d", m), m, 2, 1'b0);
        end
        fill_random(3);
        run_frame("rand_ties_med", 1, 2, 1'b0);
        fill_random(255);
        run_frame("rand_bypass", 0, 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
